// File: rtl/horblur_ctrl.sv
// Row sequencer for the horizontal blur filter: primes the filter window per row,
// registers filtered (or bypassed) pixels into a valid/ready stream, detects end of frame.
module horblur_ctrl #(
    parameter int unsigned TAPS      = 8,
    parameter int unsigned DIM_W     = 10,
    parameter logic [2:0]  BLUR_MODE = 3'b101
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic             pix_valid,
    input  logic [31:0]      pix_in,
    output logic             pix_ready,
    output logic             wb_en,
    output logic [2:0]       mode_wb,
    output logic [31:0]      wb_data,
    input  logic [31:0]      blur_in,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PRIME_W = (TAPS > 2) ? $clog2(TAPS - 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DIM_W-1:0]   r_width;
    logic [DIM_W-1:0]   r_height;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [2:0]         r_mode;
    logic [PRIME_W-1:0] r_prime_cnt;
    logic               r_out_valid;
    logic [31:0]        r_out_data;
    logic               r_busy;
    logic               r_done;

    logic w_blur;
    logic w_start_ok;
    logic w_xfer;
    logic w_row_end;
    logic w_last_row;
    logic w_prime_end;

    assign w_blur      = (r_mode == BLUR_MODE);
    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_row_end   = (r_col == (r_width - DIM_W'(1)));
    assign w_last_row  = (r_row == (r_height - DIM_W'(1)));
    assign w_prime_end = (r_prime_cnt == PRIME_W'(TAPS - 2));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the combinational filter/source handshake outputs
    always_comb begin
        w_next_state = r_state;
        pix_ready    = 1'b0;
        wb_en        = 1'b0;
        wb_data      = '0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((img_width == '0) || (img_height == '0)) begin
                        w_next_state = ST_DONE;
                    end else if (mode == BLUR_MODE) begin
                        w_next_state = ST_PRIME;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_PRIME: begin
                // Replicate the row's first pixel into the window without consuming it
                wb_en   = pix_valid;
                wb_data = pix_in;
                if (pix_valid && w_prime_end) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                pix_ready = !r_out_valid || out_ready;
                w_xfer    = pix_valid && pix_ready;
                if (w_blur) begin
                    wb_en   = w_xfer;
                    wb_data = pix_in;
                end
                if (w_xfer && w_row_end) begin
                    if (w_last_row) begin
                        w_next_state = ST_FLUSH;
                    end else if (w_blur) begin
                        w_next_state = ST_PRIME;
                    end
                end
            end
            ST_FLUSH: begin
                if (!r_out_valid || out_ready) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Frame parameters, counters and the registered output stage
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_width     <= '0;
            r_height    <= '0;
            r_mode      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_prime_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_DONE);

            if (w_start_ok) begin
                r_width     <= img_width;
                r_height    <= img_height;
                r_mode      <= mode;
                r_col       <= '0;
                r_row       <= '0;
                r_prime_cnt <= '0;
            end

            if ((r_state == ST_PRIME) && pix_valid) begin
                r_prime_cnt <= w_prime_end ? '0 : r_prime_cnt + PRIME_W'(1);
            end

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_blur ? blur_in : pix_in;
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign mode_wb   = r_mode;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_horblur_ctrl.sv
// Scoreboard bench for horblur_ctrl with a small averaging model of the horblur filter.
module tb_horblur_ctrl;

    localparam int unsigned DIM_W = 10;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [2:0]       mode;
    logic [DIM_W-1:0] img_width;
    logic [DIM_W-1:0] img_height;
    logic             pix_valid;
    logic [31:0]      pix_in;
    logic             pix_ready;
    logic             wb_en;
    logic [2:0]       mode_wb;
    logic [31:0]      wb_data;
    logic [31:0]      blur_in;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    horblur_ctrl #(
        .TAPS(8),
        .DIM_W(DIM_W),
        .BLUR_MODE(3'b101)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .mode(mode),
        .img_width(img_width),
        .img_height(img_height),
        .pix_valid(pix_valid),
        .pix_in(pix_in),
        .pix_ready(pix_ready),
        .wb_en(wb_en),
        .mode_wb(mode_wb),
        .wb_data(wb_data),
        .blur_in(blur_in),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    // Filter model: per-channel mean of the incoming pixel and the last 7 shifted pixels
    logic [31:0] f_win [0:6];
    int unsigned f_sum;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 7; k++) f_win[k] <= '0;
        end else if (wb_en) begin
            f_win[0] <= wb_data;
            for (int k = 1; k < 7; k++) f_win[k] <= f_win[k-1];
        end
    end

    always_comb begin
        blur_in = '0;
        f_sum   = 0;
        for (int c = 0; c < 4; c++) begin
            f_sum = 32'(wb_data[c*8 +: 8]);
            for (int k = 0; k < 7; k++) f_sum += 32'(f_win[k][c*8 +: 8]);
            blur_in[c*8 +: 8] = 8'(f_sum >> 3);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pix_arr [$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is popped against the scoreboard queue
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%08h expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sb_out_data", out_data, mon_exp);
            end
        end
    end

    // Drives one frame from pix_arr and returns cycle statistics up to the done pulse
    task automatic run_frame(input logic [2:0] m, input int w, input int h,
                             output int done_cyc, output int prime_cyc, output int wb_cyc);
        int  idx;
        int  cyc;
        int  npix;
        bit  prev_xfer;
        idx       = 0;
        npix      = pix_arr.size();
        prev_xfer = 1'b0;
        done_cyc  = -1;
        prime_cyc = 0;
        wb_cyc    = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        mode       = m;
        img_width  = DIM_W'(w);
        img_height = DIM_W'(h);
        pix_valid  = (npix > 0);
        if (npix > 0) pix_in = pix_arr[0];
        @(posedge clk); #1;
        start      = 1'b0;
        mode       = 3'b111;
        img_width  = '1;
        img_height = '1;
        cyc        = 1;
        while (cyc < 400) begin
            @(negedge clk);
            if (prev_xfer) check("latency_out_valid", 32'(out_valid), 32'd1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (wb_en && !pix_ready) prime_cyc++;
            if (wb_en) wb_cyc++;
            prev_xfer = pix_valid && pix_ready;
            if (prev_xfer) idx++;
            @(posedge clk); #1;
            cyc++;
            pix_valid = (idx < npix);
            if (idx < npix) pix_in = pix_arr[idx];
        end
        if (done_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 400 cycles expected done");
        end
    endtask

    task automatic after_done(input string name);
        check({name, "_busy_at_done"}, 32'(busy), 32'd1);
        check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    int d_cyc, p_cyc, w_cyc, n_done, first_done, rdy_cnt;

    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        mode       = '0;
        img_width  = '0;
        img_height = '0;
        pix_valid  = 1'b0;
        pix_in     = '0;
        out_ready  = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mode_wb", 32'(mode_wb), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Reset mid-RUN: one output buffered under backpressure, then async reset
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b011; img_width = DIM_W'(4); img_height = DIM_W'(1);
        pix_valid = 1'b1; pix_in = 32'hAAAA_5555;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_mode_wb", 32'(mode_wb), 32'd3);
        n_rst = 1'b0;
        #1;
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
        check("mid_rst_wb_en", 32'(wb_en), 32'd0);
        check("mid_rst_wb_data", wb_data, 32'd0);
        check("mid_rst_mode_wb", 32'(mode_wb), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        n_rst     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_idle_ready", 32'(pix_ready), 32'd0);
        pix_valid = 1'b0;

        // Blur 4x2 of white: 7 prime cycles per row, done 24 cycles after start
        pix_arr.delete();
        for (int i = 0; i < 8; i++) begin
            pix_arr.push_back(32'hFFFF_FFFF);
            exp_q.push_back(32'hFFFF_FFFF);
        end
        run_frame(3'b101, 4, 2, d_cyc, p_cyc, w_cyc);
        check("blur4x2_done_cycle", 32'(d_cyc), 32'd24);
        check("blur4x2_prime_cycles", 32'(p_cyc), 32'd14);
        check("blur4x2_wb_cycles", 32'(w_cyc), 32'd22);
        check("blur4x2_mode_wb", 32'(mode_wb), 32'd5);
        after_done("blur4x2");

        // Blur 3x2 of a constant grey
        pix_arr.delete();
        for (int i = 0; i < 6; i++) begin
            pix_arr.push_back(32'hFF80_8080);
            exp_q.push_back(32'hFF80_8080);
        end
        run_frame(3'b101, 3, 2, d_cyc, p_cyc, w_cyc);
        check("grey_prime_cycles", 32'(p_cyc), 32'd14);
        after_done("grey");

        // Blur 2x1 of distinct pixels: edge replication of the first pixel shows in pixel 2
        pix_arr.delete();
        pix_arr.push_back(32'h1020_3040);
        pix_arr.push_back(32'h90A0_B0C0);
        exp_q.push_back(32'h1020_3040);
        exp_q.push_back(32'h2030_4050);
        run_frame(3'b101, 2, 1, d_cyc, p_cyc, w_cyc);
        check("edge_prime_cycles", 32'(p_cyc), 32'd7);
        after_done("edge");

        // Bypass 3x1: data passes through untouched, filter never shifted
        pix_arr.delete();
        for (int i = 1; i <= 3; i++) begin
            pix_arr.push_back(32'(i));
            exp_q.push_back(32'(i));
        end
        run_frame(3'b000, 3, 1, d_cyc, p_cyc, w_cyc);
        check("bypass_wb_cycles", 32'(w_cyc), 32'd0);
        check("bypass_mode_wb", 32'(mode_wb), 32'd0);
        after_done("bypass");

        // Backpressure: sink stalls 5 cycles after the first output
        pix_arr.delete();
        for (int i = 1; i <= 6; i++) begin
            pix_arr.push_back(32'(i * 32'h11));
            exp_q.push_back(32'(i * 32'h11));
        end
        fork
            run_frame(3'b000, 6, 1, d_cyc, p_cyc, w_cyc);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_pix_ready", 32'(pix_ready), 32'd0);
                    check("bp_wb_en", 32'(wb_en), 32'd0);
                    check("bp_out_data_held", out_data, 32'h11);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        after_done("bp");

        // Zero width: immediate done, no source handshake, second start ignored
        @(posedge clk); #1;
        start = 1'b1; mode = 3'b101; img_width = '0; img_height = DIM_W'(3);
        pix_valid = 1'b1; pix_in = 32'h1234_5678;
        @(posedge clk); #1;
        mode = 3'b000; img_width = DIM_W'(3); img_height = DIM_W'(1);
        n_done = 0; first_done = -1; rdy_cnt = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
            if (pix_ready) rdy_cnt++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        pix_valid = 1'b0;
        check("w0_done_count", 32'(n_done), 32'd1);
        check("w0_done_latency_le2", 32'(first_done >= 1 && first_done <= 2), 32'd1);
        check("w0_no_pix_ready", 32'(rdy_cnt), 32'd0);
        check("w0_mode_wb_kept", 32'(mode_wb), 32'd5);
        check("w0_idle_busy", 32'(busy), 32'd0);
        check("w0_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
